// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle between a requester and the BCD-to-binary converter.
// The requester drives start/bcd_in; the converter returns status and the result.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 5,
    parameter int OUT_W  = 16
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      result;
    logic                  overflow;
    logic                  invalid;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  result,
        input  overflow,
        input  invalid
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output result,
        output overflow,
        output invalid
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Packed-BCD to binary converter: multiply-by-10 / add accumulator, one digit
// per clock, most significant digit first, saturating at 2^OUT_W-1.
module bcd_to_binary_seq #(
    parameter int DIGITS = 5,
    parameter int OUT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_to_binary_seq_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int T_W   = OUT_W + 4;
    localparam logic [T_W-1:0] MAX_T = {{4{1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [4*DIGITS-1:0] shadow_q,   shadow_d;
    logic [OUT_W-1:0]    acc_q,      acc_d;
    logic                ovf_q,      ovf_d;
    logic                inv_q,      inv_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [OUT_W-1:0]    result_q,   result_d;
    logic                overflow_q, overflow_d;
    logic                invalid_q,  invalid_d;

    logic [4*DIGITS-1:0] shifted_s;
    logic [3:0]          digit_s;
    logic [T_W-1:0]      t_s;
    logic                ovf_step_s;
    logic                inv_step_s;
    logic [OUT_W-1:0]    acc_step_s;

    // Datapath for one accumulation step using the digit selected by idx_q.
    always_comb begin
        shifted_s  = shadow_q >> {idx_q, 2'b00};
        digit_s    = shifted_s[3:0];
        t_s        = ({{4{1'b0}}, acc_q} * T_W'(10)) + {{OUT_W{1'b0}}, digit_s};
        inv_step_s = inv_q | (digit_s > 4'd9);
        ovf_step_s = ovf_q | (t_s > MAX_T);
        acc_step_s = ovf_step_s ? {OUT_W{1'b1}} : t_s[OUT_W-1:0];
    end

    // Next-state and output-register logic of the IDLE/ACC controller.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        inv_d      = inv_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = ACC;
                    busy_d   = 1'b1;
                    shadow_d = bus.bcd_in;
                    acc_d    = {OUT_W{1'b0}};
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                    idx_d    = IDX_W'(DIGITS - 1);
                end else begin
                    state_d  = IDLE;
                end
            end
            ACC: begin
                acc_d = acc_step_s;
                ovf_d = ovf_step_s;
                inv_d = inv_step_s;
                if (idx_q == {IDX_W{1'b0}}) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    // An invalid digit makes the numeric value meaningless, so it wins.
                    result_d   = inv_step_s ? {OUT_W{1'b0}} : acc_step_s;
                    overflow_d = ovf_step_s & ~inv_step_s;
                    invalid_d  = inv_step_s;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_q   <= {(4*DIGITS){1'b0}};
            acc_q      <= {OUT_W{1'b0}};
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= {OUT_W{1'b0}};
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            inv_q      <= inv_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign bus.invalid  = invalid_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: scoreboard of expected results
// checked on every done pulse, plus per-scenario latency and flag checks.
module tb_bcd_to_binary_seq;
    localparam int DIGITS = 5;
    localparam int OUT_W  = 16;
    localparam int LIMIT  = 20;

    typedef struct packed {
        logic [OUT_W-1:0] result;
        logic             overflow;
        logic             invalid;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   prev_done;
    exp_t sb[$];

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .OUT_W(OUT_W)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true decimal value, then classify as invalid / overflow / normal.
    function automatic exp_t model(input logic [4*DIGITS-1:0] b);
        exp_t        e;
        int unsigned val;
        bit          inv;
        logic [3:0]  d;
        val = 0;
        inv = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) inv = 1'b1;
            val = val * 10 + int'(d);
        end
        if (inv) begin
            e.result = '0; e.overflow = 1'b0; e.invalid = 1'b1;
        end else if (val > 32'd65535) begin
            e.result = '1; e.overflow = 1'b1; e.invalid = 1'b0;
        end else begin
            e.result = val[OUT_W-1:0]; e.overflow = 1'b0; e.invalid = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: done high for 2+ cycles, required 1");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done with no pending conversion, result=%h", bus.result);
            end else begin
                e = sb.pop_front();
                if ({bus.result, bus.overflow, bus.invalid} !== {e.result, e.overflow, e.invalid})
                begin
                    errors++;
                    $display("FAIL scoreboard: got result=%h ovf=%b inv=%b, required result=%h ovf=%b inv=%b",
                             bus.result, bus.overflow, bus.invalid, e.result, e.overflow, e.invalid);
                end
            end
        end
        prev_done = (bus.done === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) n = 99;
    endtask

    // One-cycle start pulse; lat counts edges from the start sample to done visible.
    task automatic run_conv(input logic [4*DIGITS-1:0] b, output int lat);
        int n;
        sb.push_back(model(b));
        bus.bcd_in = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done(n);
        lat = n + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.overflow, bus.invalid} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h ovf=%b inv=%b, required all 0",
                     bus.busy, bus.done, bus.result, bus.overflow, bus.invalid);
        end
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        run_conv(20'h54231, lat);
        checks++;
        if (lat !== DIGITS + 1) begin
            errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, DIGITS + 1);
        end
        checks++;
        if (bus.result !== 16'hD3D7 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_result: result=%h busy=%b, required D3D7 busy=0", bus.result, bus.busy);
        end
    endtask

    task automatic test_saturation();
        logic [19:0] vals [3];
        logic        ovfs [3];
        int          lat;
        vals = '{20'h65535, 20'h65536, 20'h99999};
        ovfs = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], lat);
            checks++;
            if (lat !== DIGITS + 1 || bus.result !== 16'hFFFF || bus.overflow !== ovfs[i]) begin
                errors++;
                $display("FAIL saturation_%0d: lat=%0d result=%h ovf=%b, required lat=%0d FFFF ovf=%b",
                         i, lat, bus.result, bus.overflow, DIGITS + 1, ovfs[i]);
            end
        end
    endtask

    task automatic test_invalid();
        int lat;
        run_conv(20'h12A45, lat);
        checks++;
        if (bus.invalid !== 1'b1 || bus.overflow !== 1'b0 || bus.result !== 16'h0000) begin
            errors++;
            $display("FAIL invalid_flag: inv=%b ovf=%b result=%h, required 1 0 0000",
                     bus.invalid, bus.overflow, bus.result);
        end
        run_conv(20'h00007, lat);
        checks++;
        if (bus.invalid !== 1'b0 || bus.result !== 16'h0007) begin
            errors++; $display("FAIL invalid_clear: inv=%b result=%h, required 0 0007", bus.invalid, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int lat;
        sb.push_back(model(20'h00100));
        bus.bcd_in = 20'h00100;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL busy_mid: busy=%b, required 1", bus.busy);
        end
        bus.start  = 1'b1;
        bus.bcd_in = 20'h99999;
        tick();
        bus.start  = 1'b0;
        bus.bcd_in = 20'h12345;
        wait_done(n);
        checks++;
        if (n !== DIGITS - 2 || bus.result !== 16'd100 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: remaining=%0d result=%h ovf=%b, required %0d 0064 0",
                     n, bus.result, bus.overflow, DIGITS - 2);
        end
        run_conv(20'h00042, lat);
        checks++;
        if (lat !== DIGITS + 1 || bus.result !== 16'd42) begin
            errors++; $display("FAIL back_to_back: lat=%0d result=%h, required %0d 002A", lat, bus.result, DIGITS + 1);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        int lat;
        bus.bcd_in = 20'h54231;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.overflow, bus.invalid} !== '0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b result=%h ovf=%b inv=%b, required all 0",
                     bus.busy, bus.done, bus.result, bus.overflow, bus.invalid);
        end
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL abort_no_done: %0d done pulses, required 0", dones);
        end
        run_conv(20'h54231, lat);
        checks++;
        if (lat !== DIGITS + 1 || bus.result !== 16'hD3D7) begin
            errors++; $display("FAIL after_abort: lat=%0d result=%h, required %0d D3D7", lat, bus.result, DIGITS + 1);
        end
    endtask

    task automatic test_zero();
        int lat;
        run_conv(20'h00000, lat);
        checks++;
        if (lat !== DIGITS + 1 || bus.result !== 16'h0000 || bus.overflow !== 1'b0 || bus.invalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_input: lat=%0d result=%h ovf=%b inv=%b, required %0d 0000 0 0",
                     lat, bus.result, bus.overflow, bus.invalid, DIGITS + 1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        prev_done  = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_invalid();
        test_back_to_back();
        test_reset_abort();
        test_zero();
        repeat (3) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL pending: %0d conversions never completed, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
